// File: rtl/counter_7seg_mux.sv
// counter_7seg_mux: multi-digit BCD up/down event counter with prescaled
// count tick, synchronous load with nibble clamping, wrap pulse, and a
// time-multiplexed seven-segment output with optional leading-zero blanking.
module counter_7seg_mux #(
    parameter int DIGITS   = 4,
    parameter int PRESCALE = 10,
    parameter int SCAN_DIV = 4,
    parameter int BLANK_LZ = 0
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_freeze,
    input  logic                  i_up,
    input  logic                  i_load,
    input  logic [4*DIGITS-1:0]   i_load_value,
    output logic [6:0]            o_display,
    output logic [DIGITS-1:0]     o_digit_sel,
    output logic [4*DIGITS-1:0]   o_bcd,
    output logic                  o_wrap
);

    localparam int PW  = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam int SCW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int SW  = (DIGITS > 1)   ? $clog2(DIGITS)   : 1;

    localparam logic [PW-1:0]  PRESC_LAST = PW'(PRESCALE - 1);
    localparam logic [SCW-1:0] SCAN_LAST  = SCW'(SCAN_DIV - 1);
    localparam logic [SW-1:0]  IDX_LAST   = SW'(DIGITS - 1);

    logic [PW-1:0]         r_presc;
    logic [4*DIGITS-1:0]   r_bcd;
    logic                  r_wrap;
    logic [SCW-1:0]        r_scan_cnt;
    logic [SW-1:0]         r_scan_idx;
    logic [DIGITS-1:0]     r_digit_sel;

    logic                  w_tick;
    logic [4*DIGITS-1:0]   w_bcd_next;
    logic [4*DIGITS-1:0]   w_load_clamped;
    logic [DIGITS:0]       w_ripple;
    logic [DIGITS:0]       w_zero_from;
    logic [3:0]            w_digit;
    logic                  w_blank;
    logic [6:0]            w_seg;

    // Load and freeze both suppress the tick; load additionally restarts the prescaler.
    assign w_tick = (r_presc == PRESC_LAST) && !i_freeze && !i_load;

    // Prescaler: divides the system clock down to the count tick.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_presc <= '0;
        end else if (i_load) begin
            r_presc <= '0;
        end else if (!i_freeze) begin
            if (r_presc == PRESC_LAST) r_presc <= '0;
            else                       r_presc <= r_presc + 1'b1;
        end
    end

    // Ripple carry/borrow across digits, plus clamping of the load value.
    always_comb begin
        w_bcd_next     = r_bcd;
        w_load_clamped = i_load_value;
        w_ripple       = '0;
        w_ripple[0]    = 1'b1;
        for (int i = 0; i < DIGITS; i++) begin
            if (w_ripple[i]) begin
                if (i_up) begin
                    if (r_bcd[4*i +: 4] >= 4'd9) begin
                        w_bcd_next[4*i +: 4] = 4'd0;
                        w_ripple[i+1]        = 1'b1;
                    end else begin
                        w_bcd_next[4*i +: 4] = r_bcd[4*i +: 4] + 4'd1;
                    end
                end else begin
                    if (r_bcd[4*i +: 4] == 4'd0) begin
                        w_bcd_next[4*i +: 4] = 4'd9;
                        w_ripple[i+1]        = 1'b1;
                    end else begin
                        w_bcd_next[4*i +: 4] = r_bcd[4*i +: 4] - 4'd1;
                    end
                end
            end
            if (i_load_value[4*i +: 4] > 4'd9) w_load_clamped[4*i +: 4] = 4'd9;
        end
    end

    // Count register and wrap pulse; a ripple out of the top digit is a wrap.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_bcd  <= '0;
            r_wrap <= 1'b0;
        end else if (i_load) begin
            r_bcd  <= w_load_clamped;
            r_wrap <= 1'b0;
        end else if (w_tick) begin
            r_bcd  <= w_bcd_next;
            r_wrap <= w_ripple[DIGITS];
        end else begin
            r_wrap <= 1'b0;
        end
    end

    // Digit scanner: runs regardless of freeze and load.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_scan_cnt  <= '0;
            r_scan_idx  <= '0;
            r_digit_sel <= DIGITS'(1);
        end else if (r_scan_cnt == SCAN_LAST) begin
            r_scan_cnt <= '0;
            if (r_scan_idx == IDX_LAST) begin
                r_scan_idx  <= '0;
                r_digit_sel <= DIGITS'(1);
            end else begin
                r_scan_idx  <= r_scan_idx + 1'b1;
                r_digit_sel <= r_digit_sel << 1;
            end
        end else begin
            r_scan_cnt <= r_scan_cnt + 1'b1;
        end
    end

    // Select the scanned digit and decide whether it is a blanked leading zero.
    always_comb begin
        w_digit     = 4'd0;
        w_blank     = 1'b0;
        w_zero_from = '0;
        w_zero_from[DIGITS] = 1'b1;
        for (int i = DIGITS - 1; i >= 0; i--) begin
            w_zero_from[i] = w_zero_from[i+1] && (r_bcd[4*i +: 4] == 4'd0);
        end
        for (int i = 0; i < DIGITS; i++) begin
            if (r_scan_idx == SW'(i)) begin
                w_digit = r_bcd[4*i +: 4];
                w_blank = (BLANK_LZ != 0) && (i != 0) && w_zero_from[i];
            end
        end
    end

    // Seven-segment decode {g,f,e,d,c,b,a}.
    always_comb begin
        w_seg = 7'b0000000;
        case (w_digit)
            4'd0: w_seg = 7'b0111111;
            4'd1: w_seg = 7'b0000110;
            4'd2: w_seg = 7'b1011011;
            4'd3: w_seg = 7'b1001111;
            4'd4: w_seg = 7'b1100110;
            4'd5: w_seg = 7'b1101101;
            4'd6: w_seg = 7'b1111101;
            4'd7: w_seg = 7'b0000111;
            4'd8: w_seg = 7'b1111111;
            4'd9: w_seg = 7'b1101111;
            default: w_seg = 7'b0000000;
        endcase
    end

    assign o_display   = w_blank ? 7'b0000000 : w_seg;
    assign o_digit_sel = r_digit_sel;
    assign o_bcd       = r_bcd;
    assign o_wrap      = r_wrap;

endmodule

// File: tb/tb_counter_7seg_mux.sv
// Testbench for counter_7seg_mux: DIGITS=4, PRESCALE=10, SCAN_DIV=4, with a
// second instance built with leading-zero blanking sharing the same inputs.
module tb_counter_7seg_mux;

    logic        clk = 1'b0;
    logic        rst, freeze, up, load;
    logic [15:0] load_value;
    logic [6:0]  display, display_lz;
    logic [3:0]  digit_sel, digit_sel_lz;
    logic [15:0] bcd, bcd_lz;
    logic        wrap, wrap_lz;

    int errors = 0;
    int checks = 0;

    // Reference scan position, tracked independently from reset.
    int m_cnt = 0;
    int m_idx = 0;

    counter_7seg_mux #(.DIGITS(4), .PRESCALE(10), .SCAN_DIV(4), .BLANK_LZ(0)) u_dut (
        .i_clk(clk), .i_rst(rst), .i_freeze(freeze), .i_up(up), .i_load(load),
        .i_load_value(load_value), .o_display(display), .o_digit_sel(digit_sel),
        .o_bcd(bcd), .o_wrap(wrap)
    );

    counter_7seg_mux #(.DIGITS(4), .PRESCALE(10), .SCAN_DIV(4), .BLANK_LZ(1)) u_dut_lz (
        .i_clk(clk), .i_rst(rst), .i_freeze(freeze), .i_up(up), .i_load(load),
        .i_load_value(load_value), .o_display(display_lz), .o_digit_sel(digit_sel_lz),
        .o_bcd(bcd_lz), .o_wrap(wrap_lz)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (rst) begin
            m_cnt <= 0;
            m_idx <= 0;
        end else if (m_cnt == 3) begin
            m_cnt <= 0;
            m_idx <= (m_idx == 3) ? 0 : m_idx + 1;
        end else begin
            m_cnt <= m_cnt + 1;
        end
    end

    typedef struct {
        logic [15:0] lv;
        logic        dir_up;
        logic [15:0] exp_load;
        logic [15:0] exp_tick;
        logic        exp_wrap;
    } vec_t;

    vec_t vecs[8];

    function automatic logic [6:0] seg(input logic [3:0] d);
        case (d)
            4'd0: return 7'b0111111;
            4'd1: return 7'b0000110;
            4'd2: return 7'b1011011;
            4'd3: return 7'b1001111;
            4'd4: return 7'b1100110;
            4'd5: return 7'b1101101;
            4'd6: return 7'b1111101;
            4'd7: return 7'b0000111;
            4'd8: return 7'b1111111;
            4'd9: return 7'b1101111;
            default: return 7'b0000000;
        endcase
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_load(input logic [15:0] v);
        load       = 1'b1;
        load_value = v;
        step();
        load       = 1'b0;
    endtask

    logic [6:0] exp_plain, exp_lz;
    bit         found;

    initial begin
        vecs[0] = '{16'h9999, 1'b1, 16'h9999, 16'h0000, 1'b1};
        vecs[1] = '{16'h0199, 1'b1, 16'h0199, 16'h0200, 1'b0};
        vecs[2] = '{16'h0100, 1'b0, 16'h0100, 16'h0099, 1'b0};
        vecs[3] = '{16'h0000, 1'b0, 16'h0000, 16'h9999, 1'b1};
        vecs[4] = '{16'hAF37, 1'b1, 16'h9937, 16'h9938, 1'b0};
        vecs[5] = '{16'h1234, 1'b0, 16'h1234, 16'h1233, 1'b0};
        vecs[6] = '{16'h0909, 1'b1, 16'h0909, 16'h0910, 1'b0};
        vecs[7] = '{16'hFFFF, 1'b0, 16'h9999, 16'h9998, 1'b0};

        rst = 1'b1; freeze = 1'b0; up = 1'b1; load = 1'b0; load_value = 16'h0000;
        step();
        step();
        check("reset_bcd", bcd, 16'h0000);
        check("reset_sel", digit_sel, 4'b0001);
        check("reset_display", display, 7'b0111111);
        check("reset_wrap", wrap, 1'b0);
        rst = 1'b0;

        repeat (9) step();
        check("count_before_first_tick", bcd, 16'h0000);
        step();
        check("count_first_tick", bcd, 16'h0001);
        repeat (110) step();
        check("count_120_edges", bcd, 16'h0012);

        // Load in the same cycle a tick is due: the load must win.
        repeat (9) step();
        do_load(16'h5555);
        check("load_vs_tick", bcd, 16'h5555);
        check("load_vs_tick_wrap", wrap, 1'b0);
        repeat (9) step();
        check("load_tick_hold", bcd, 16'h5555);
        step();
        check("load_next_tick", bcd, 16'h5556);

        foreach (vecs[i]) begin
            up = vecs[i].dir_up;
            do_load(vecs[i].lv);
            check($sformatf("vec%0d_load", i), bcd, vecs[i].exp_load);
            check($sformatf("vec%0d_load_wrap", i), wrap, 1'b0);
            repeat (9) step();
            check($sformatf("vec%0d_hold", i), bcd, vecs[i].exp_load);
            step();
            check($sformatf("vec%0d_tick", i), bcd, vecs[i].exp_tick);
            check($sformatf("vec%0d_wrap", i), wrap, vecs[i].exp_wrap);
            step();
            check($sformatf("vec%0d_wrap_end", i), wrap, 1'b0);
        end

        // Freeze at prescaler=5 for 50 cycles; direction flips while frozen are ignored.
        up = 1'b1;
        do_load(16'h0123);
        repeat (5) step();
        freeze = 1'b1;
        for (int c = 0; c < 50; c++) begin
            if (c == 20) up = 1'b0;
            if (c == 30) up = 1'b1;
            step();
            check($sformatf("freeze_bcd_c%0d", c), bcd, 16'h0123);
            check($sformatf("freeze_sel_c%0d", c), digit_sel, 4'b0001 << m_idx);
        end
        freeze = 1'b0;
        repeat (4) step();
        check("unfreeze_hold", bcd, 16'h0123);
        step();
        check("unfreeze_tick", bcd, 16'h0124);

        // Load takes priority over freeze.
        freeze = 1'b1;
        do_load(16'h0777);
        check("load_over_freeze", bcd, 16'h0777);

        // Blanking over a full frame (still frozen so bcd holds).
        do_load(16'h0040);
        for (int c = 0; c < 16; c++) begin
            step();
            case (m_idx)
                0: begin exp_plain = seg(4'd0); exp_lz = seg(4'd0); end
                1: begin exp_plain = seg(4'd4); exp_lz = seg(4'd4); end
                default: begin exp_plain = seg(4'd0); exp_lz = 7'b0000000; end
            endcase
            check($sformatf("scan_sel_c%0d", c), digit_sel, 4'b0001 << m_idx);
            check($sformatf("scan_disp_c%0d", c), display, exp_plain);
            check($sformatf("scan_disp_lz_c%0d", c), display_lz, exp_lz);
        end

        // Reset in the middle of a frame.
        found = 1'b0;
        for (int c = 0; c < 20 && !found; c++) begin
            if (m_idx == 2 && m_cnt == 1) found = 1'b1;
            else step();
        end
        check("midframe_reach", found, 1'b1);
        rst = 1'b1;
        step();
        rst = 1'b0;
        freeze = 1'b0;
        check("midframe_rst_sel", digit_sel, 4'b0001);
        check("midframe_rst_bcd", bcd, 16'h0000);
        check("midframe_rst_display", display, 7'b0111111);
        check("midframe_rst_display_lz", display_lz, 7'b0111111);
        step();
        check("midframe_sel_after", digit_sel, 4'b0001);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
